// File: rtl/dmem_bist_master.sv
// Data-memory BIST initiator: writes an address-derived pattern over a window
// of data memory, reads it back with a one-stage compare pipeline, and
// reports pass/fail, a saturating mismatch count and the first failing address.
module dmem_bist_master #(
   parameter logic [15:0] BASE    = 16'h0000,
   parameter int          COUNT   = 16,
   parameter logic [15:0] STEP    = 16'd2,
   parameter logic [15:0] PATTERN = 16'hA5A5
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   output logic [15:0] dmemaddr,
   output logic [15:0] dmemwdata,
   output logic        dmemwrite,
   output logic        dmemread,
   input  logic [15:0] dmemrdata,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [7:0]  err_count,
   output logic [15:0] first_err_addr
);

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      READ,
      DRAIN,
      DONE
   } state_t;

   // Index of the final word; the walk counter stops here in both phases.
   localparam logic [15:0] LAST = 16'(COUNT - 1);

   state_t      state;
   state_t      state_next;
   logic [15:0] idx;
   logic [15:0] idx_next;

   // Compare pipeline: set in the cycle after a read was issued, holding the
   // address that read targeted so the expected word can be rebuilt.
   logic        cmp_valid;
   logic        cmp_valid_next;
   logic [15:0] cmp_addr;
   logic [15:0] cmp_addr_next;

   logic [15:0] addr_next;
   logic [15:0] wdata_next;
   logic        write_next;
   logic        read_next;
   logic        busy_next;
   logic        done_next;
   logic        pass_next;
   logic [7:0]  err_next;
   logic [15:0] first_next;

   logic [15:0] addr_inc;
   logic        mismatch;
   logic [7:0]  err_after;
   logic [15:0] first_after;

   // Result of this cycle's compare folded into the error counters.
   always_comb begin
      addr_inc    = dmemaddr + STEP;
      mismatch    = cmp_valid && (dmemrdata != (cmp_addr ^ PATTERN));
      err_after   = err_count;
      first_after = first_err_addr;
      if (mismatch) begin
         if (err_count != 8'hFF) begin
            err_after = err_count + 8'd1;
         end
         if (err_count == 8'd0) begin
            first_after = cmp_addr;
         end
      end
   end

   // Next-state and next-output decode; every bus output is registered.
   always_comb begin
      state_next     = state;
      idx_next       = idx;
      cmp_valid_next = (state == READ);
      cmp_addr_next  = dmemaddr;
      addr_next      = dmemaddr;
      wdata_next     = dmemwdata;
      write_next     = 1'b0;
      read_next      = 1'b0;
      busy_next      = busy;
      done_next      = done;
      pass_next      = pass;
      err_next       = err_after;
      first_next     = first_after;

      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_next = WRITE;
               idx_next   = 16'd0;
               addr_next  = BASE;
               wdata_next = BASE ^ PATTERN;
               write_next = 1'b1;
               busy_next  = 1'b1;
               done_next  = 1'b0;
               pass_next  = 1'b0;
               err_next   = 8'd0;
               first_next = 16'd0;
            end
         end
         WRITE: begin
            if (idx == LAST) begin
               state_next = READ;
               idx_next   = 16'd0;
               addr_next  = BASE;
               read_next  = 1'b1;
            end else begin
               idx_next   = idx + 16'd1;
               addr_next  = addr_inc;
               wdata_next = addr_inc ^ PATTERN;
               write_next = 1'b1;
            end
         end
         READ: begin
            if (idx == LAST) begin
               state_next = DRAIN;
            end else begin
               idx_next  = idx + 16'd1;
               addr_next = addr_inc;
               read_next = 1'b1;
            end
         end
         DRAIN: begin
            state_next = DONE;
            busy_next  = 1'b0;
            done_next  = 1'b1;
            pass_next  = (err_after == 8'd0);
         end
         default: begin
            state_next = IDLE;
            busy_next  = 1'b0;
            done_next  = 1'b0;
         end
      endcase
   end

   // Control state register: FSM state, walk index and compare pipeline.
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         idx       <= 16'd0;
         cmp_valid <= 1'b0;
         cmp_addr  <= 16'd0;
      end else begin
         state     <= state_next;
         idx       <= idx_next;
         cmp_valid <= cmp_valid_next;
         cmp_addr  <= cmp_addr_next;
      end
   end

   // Output registers for the memory bus and the status/result ports.
   always_ff @(posedge clock) begin
      if (reset) begin
         dmemaddr       <= 16'd0;
         dmemwdata      <= 16'd0;
         dmemwrite      <= 1'b0;
         dmemread       <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         err_count      <= 8'd0;
         first_err_addr <= 16'd0;
      end else begin
         dmemaddr       <= addr_next;
         dmemwdata      <= wdata_next;
         dmemwrite      <= write_next;
         dmemread       <= read_next;
         busy           <= busy_next;
         done           <= done_next;
         pass           <= pass_next;
         err_count      <= err_next;
         first_err_addr <= first_next;
      end
   end

endmodule

// File: tb/tb_dmem_bist_master.sv
// Self-checking bench for dmem_bist_master: three instances (clean window,
// wrapping window, long all-ones window) share a behavioural data memory.
module tb_dmem_bist_master;

   logic        clock;
   logic        reset_b  [3];
   logic        start_b  [3];
   logic [15:0] addr_b   [3];
   logic [15:0] wdata_b  [3];
   logic        write_b  [3];
   logic        read_b   [3];
   logic [15:0] rdata_b  [3];
   logic        busy_b   [3];
   logic        done_b   [3];
   logic        pass_b   [3];
   logic [7:0]  err_b    [3];
   logic [15:0] first_b  [3];

   logic        fault_en   [3];
   logic [15:0] fault_addr [3];
   logic        all_ones   [3];

   logic [15:0] mem [logic [17:0]];
   logic [31:0] exp_q [$];

   int vectors;
   int miscompares;

   dmem_bist_master #(.BASE(16'h0000), .COUNT(4)) dut (
      .clock(clock), .reset(reset_b[0]), .start(start_b[0]),
      .dmemaddr(addr_b[0]), .dmemwdata(wdata_b[0]), .dmemwrite(write_b[0]),
      .dmemread(read_b[0]), .dmemrdata(rdata_b[0]), .busy(busy_b[0]),
      .done(done_b[0]), .pass(pass_b[0]), .err_count(err_b[0]),
      .first_err_addr(first_b[0])
   );

   dmem_bist_master #(.BASE(16'hFFFC), .COUNT(4)) dut_wrap (
      .clock(clock), .reset(reset_b[1]), .start(start_b[1]),
      .dmemaddr(addr_b[1]), .dmemwdata(wdata_b[1]), .dmemwrite(write_b[1]),
      .dmemread(read_b[1]), .dmemrdata(rdata_b[1]), .busy(busy_b[1]),
      .done(done_b[1]), .pass(pass_b[1]), .err_count(err_b[1]),
      .first_err_addr(first_b[1])
   );

   dmem_bist_master #(.BASE(16'h1234), .COUNT(300)) dut_sat (
      .clock(clock), .reset(reset_b[2]), .start(start_b[2]),
      .dmemaddr(addr_b[2]), .dmemwdata(wdata_b[2]), .dmemwrite(write_b[2]),
      .dmemread(read_b[2]), .dmemrdata(rdata_b[2]), .busy(busy_b[2]),
      .done(done_b[2]), .pass(pass_b[2]), .err_count(err_b[2]),
      .first_err_addr(first_b[2])
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Behavioural memory with one-cycle read latency, fault and all-ones hooks.
   always @(posedge clock) begin
      for (int u = 0; u < 3; u++) begin
         logic [17:0] key;
         key = {2'(u), addr_b[u]};
         if (write_b[u]) begin
            mem[key] = wdata_b[u];
         end
         if (read_b[u]) begin
            if (all_ones[u]) begin
               rdata_b[u] <= 16'hFFFF;
            end else if (fault_en[u] && addr_b[u] == fault_addr[u]) begin
               rdata_b[u] <= 16'h0000;
            end else if (mem.exists(key)) begin
               rdata_b[u] <= mem[key];
            end else begin
               rdata_b[u] <= 16'hDEAD;
            end
         end else begin
            rdata_b[u] <= 16'hDEAD;
         end
      end
   end

   // Hard stop in case anything in the sequence fails to make progress.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input int u);
      @(negedge clock);
      start_b[u] = 1'b1;
      @(negedge clock);
      start_b[u] = 1'b0;
   endtask

   // Pushes the expected write stream, launches a test, scoreboards the bus
   // each cycle while busy, then checks the final result registers.
   task automatic runTest(input int u, input logic [15:0] base, input int count,
                          input int startAt, input logic [15:0] expErr,
                          input logic [15:0] expFirst, input logic [15:0] expPass);
      logic [15:0] a;
      logic [31:0] e;
      int cyc;
      int rd_idx;
      for (int i = 0; i < count; i++) begin
         a = base + 16'(i * 2);
         exp_q.push_back({a, a ^ 16'hA5A5});
      end
      applyStimulus(u);
      cyc    = 0;
      rd_idx = 0;
      while (busy_b[u] && cyc < 2 * count + 20) begin
         cyc++;
         start_b[u] = (cyc == startAt);
         if (write_b[u]) begin
            if (exp_q.size() == 0) begin
               checkOutput($sformatf("u%0d_write_extra", u), 16'(exp_q.size()), 16'd1);
            end else begin
               e = exp_q.pop_front();
               checkOutput($sformatf("u%0d_wr_addr", u), addr_b[u], e[31:16]);
               checkOutput($sformatf("u%0d_wr_data", u), wdata_b[u], e[15:0]);
               checkOutput($sformatf("u%0d_wr_noread", u), 16'(read_b[u]), 16'd0);
            end
         end
         if (read_b[u]) begin
            checkOutput($sformatf("u%0d_rd_addr%0d", u, rd_idx), addr_b[u],
                        base + 16'(rd_idx * 2));
            rd_idx++;
         end
         @(negedge clock);
      end
      start_b[u] = 1'b0;
      checkOutput($sformatf("u%0d_busy_cycles", u), 16'(cyc), 16'(2 * count + 1));
      checkOutput($sformatf("u%0d_writes_left", u), 16'(exp_q.size()), 16'd0);
      checkOutput($sformatf("u%0d_reads", u), 16'(rd_idx), 16'(count));
      checkOutput($sformatf("u%0d_done", u), 16'(done_b[u]), 16'd1);
      checkOutput($sformatf("u%0d_busy_low", u), 16'(busy_b[u]), 16'd0);
      checkOutput($sformatf("u%0d_pass", u), 16'(pass_b[u]), expPass);
      checkOutput($sformatf("u%0d_err_count", u), 16'(err_b[u]), expErr);
      checkOutput($sformatf("u%0d_first_err", u), first_b[u], expFirst);
      checkOutput($sformatf("u%0d_enables", u), 16'({write_b[u], read_b[u]}), 16'd0);
      checkOutput($sformatf("u%0d_addr_hold", u), addr_b[u], base + 16'((count - 1) * 2));
      exp_q.delete();
   endtask

   // Directed sequence of scenarios.
   initial begin
      vectors     = 0;
      miscompares = 0;
      for (int u = 0; u < 3; u++) begin
         reset_b[u]    = 1'b1;
         start_b[u]    = 1'b0;
         fault_en[u]   = 1'b0;
         fault_addr[u] = 16'h0000;
         all_ones[u]   = 1'b0;
      end
      all_ones[2] = 1'b1;
      repeat (3) @(negedge clock);
      for (int u = 0; u < 3; u++) reset_b[u] = 1'b0;
      @(negedge clock);

      $display("[TB] reset values");
      checkOutput("rst_addr", addr_b[0], 16'h0000);
      checkOutput("rst_wdata", wdata_b[0], 16'h0000);
      checkOutput("rst_write", 16'(write_b[0]), 16'd0);
      checkOutput("rst_read", 16'(read_b[0]), 16'd0);
      checkOutput("rst_busy", 16'(busy_b[0]), 16'd0);
      checkOutput("rst_done", 16'(done_b[0]), 16'd0);
      checkOutput("rst_pass", 16'(pass_b[0]), 16'd0);
      checkOutput("rst_err", 16'(err_b[0]), 16'd0);
      checkOutput("rst_first", first_b[0], 16'h0000);

      $display("[TB] clean memory");
      runTest(0, 16'h0000, 4, 0, 16'd0, 16'h0000, 16'd1);

      $display("[TB] single fault at 0004");
      fault_en[0]   = 1'b1;
      fault_addr[0] = 16'h0004;
      runTest(0, 16'h0000, 4, 0, 16'd1, 16'h0004, 16'd0);
      fault_en[0] = 1'b0;

      $display("[TB] start pulsed during READ");
      runTest(0, 16'h0000, 4, 6, 16'd0, 16'h0000, 16'd1);

      $display("[TB] reset on second write cycle");
      applyStimulus(0);
      @(negedge clock);
      reset_b[0] = 1'b1;
      @(negedge clock);
      reset_b[0] = 1'b0;
      checkOutput("midrst_write", 16'(write_b[0]), 16'd0);
      checkOutput("midrst_busy", 16'(busy_b[0]), 16'd0);
      checkOutput("midrst_done", 16'(done_b[0]), 16'd0);
      checkOutput("midrst_addr", addr_b[0], 16'h0000);
      repeat (2) @(negedge clock);
      checkOutput("midrst_idle", 16'(busy_b[0]), 16'd0);
      runTest(0, 16'h0000, 4, 0, 16'd0, 16'h0000, 16'd1);

      $display("[TB] start and reset together");
      @(negedge clock);
      reset_b[0] = 1'b1;
      start_b[0] = 1'b1;
      @(negedge clock);
      reset_b[0] = 1'b0;
      start_b[0] = 1'b0;
      checkOutput("rststart_busy", 16'(busy_b[0]), 16'd0);
      checkOutput("rststart_write", 16'(write_b[0]), 16'd0);
      checkOutput("rststart_done", 16'(done_b[0]), 16'd0);

      $display("[TB] wrapping window");
      runTest(1, 16'hFFFC, 4, 0, 16'd0, 16'h0000, 16'd1);

      $display("[TB] error count saturation");
      runTest(2, 16'h1234, 300, 0, 16'd255, 16'h1234, 16'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
